// File: rtl/ps2_arrow_decoder_if.sv
// Bundle between the PS/2 byte receiver / shake sensors and the two player processors.
// The master drives bytes and sensor levels; the slave (decoder) drives per-player events.
interface ps2_arrow_decoder_if;
    logic [7:0] ps2_key_data;
    logic       ps2_key_pressed;
    logic       shake1_in;
    logic       shake2_in;
    logic       p1_key_pressed;
    logic [7:0] p1_arrow;
    logic       p2_key_pressed;
    logic [7:0] p2_arrow;
    logic       game_reset_req;

    modport master (
        output ps2_key_data, ps2_key_pressed, shake1_in, shake2_in,
        input  p1_key_pressed, p1_arrow, p2_key_pressed, p2_arrow, game_reset_req
    );

    modport slave (
        input  ps2_key_data, ps2_key_pressed, shake1_in, shake2_in,
        output p1_key_pressed, p1_arrow, p2_key_pressed, p2_arrow, game_reset_req
    );
endinterface

// File: rtl/ps2_arrow_decoder.sv
// Turns the raw PS/2 byte stream and two async shake sensors into one clean
// event pulse plus arrow code per player, and a keyboard game-reset request.
module ps2_arrow_decoder #(
    parameter logic [15:0] SHAKE_DEBOUNCE = 16'd50000,
    parameter int          DB_W           = 16,
    parameter logic [7:0]  RESET_CODE     = 8'h2D
) (
    input logic                clock,
    input logic                resetn,
    ps2_arrow_decoder_if.slave bus
);
    typedef enum logic [1:0] {IDLE, EXT, BRK, EXT_BRK} state_t;

    localparam logic [2:0]      SHAKE_CODE = 3'd5;
    localparam logic [DB_W-1:0] DB_LAST    = DB_W'(SHAKE_DEBOUNCE - 16'd1);

    state_t          state, state_nx;
    logic [2:0]      held     [2];
    logic [2:0]      pend     [2];
    logic [1:0]      sync_a, sync_b, db_lvl;
    logic [DB_W-1:0] db_cnt   [2];
    logic            pulse    [2];
    logic [7:0]      arrow    [2];
    logic            rst_req;

    logic [2:0]      make_code[2];
    logic [2:0]      brk_code [2];
    logic [2:0]      key_ev   [2];
    logic [1:0]      shake_ev;
    logic            rst_hit;
    logic [1:0]      shake_raw;

    function automatic logic [2:0] p1_map(input logic [7:0] b);
        case (b)
            8'h1D:   p1_map = 3'd1;
            8'h1C:   p1_map = 3'd2;
            8'h1B:   p1_map = 3'd3;
            8'h23:   p1_map = 3'd4;
            default: p1_map = 3'd0;
        endcase
    endfunction

    function automatic logic [2:0] p2_map(input logic [7:0] b);
        case (b)
            8'h75:   p2_map = 3'd1;
            8'h6B:   p2_map = 3'd2;
            8'h72:   p2_map = 3'd3;
            8'h74:   p2_map = 3'd4;
            default: p2_map = 3'd0;
        endcase
    endfunction

    assign shake_raw = {bus.shake2_in, bus.shake1_in};

    // Code 0 on make_code/brk_code means "no make/break for this player this cycle".
    always_comb begin
        state_nx = state;
        rst_hit  = 1'b0;
        for (int unsigned i = 0; i < 2; i++) begin
            make_code[i] = '0;
            brk_code[i]  = '0;
        end
        if (bus.ps2_key_pressed) begin
            state_nx = IDLE;
            case (state)
                IDLE: begin
                    if (bus.ps2_key_data == 8'hE0)      state_nx = EXT;
                    else if (bus.ps2_key_data == 8'hF0) state_nx = BRK;
                    else begin
                        make_code[0] = p1_map(bus.ps2_key_data);
                        make_code[1] = p2_map(bus.ps2_key_data);
                        rst_hit      = (bus.ps2_key_data == RESET_CODE);
                    end
                end
                EXT: begin
                    if (bus.ps2_key_data == 8'hF0) state_nx = EXT_BRK;
                    else                           make_code[1] = p2_map(bus.ps2_key_data);
                end
                BRK: begin
                    brk_code[0] = p1_map(bus.ps2_key_data);
                    brk_code[1] = p2_map(bus.ps2_key_data);
                end
                EXT_BRK: brk_code[1] = p2_map(bus.ps2_key_data);
                default: state_nx = IDLE;
            endcase
        end
        for (int unsigned i = 0; i < 2; i++) begin
            shake_ev[i] = sync_b[i] && !db_lvl[i] && (db_cnt[i] == DB_LAST);
            key_ev[i]   = (make_code[i] != 3'd0 && make_code[i] != held[i]) ? make_code[i] : 3'd0;
        end
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state   <= IDLE;
            sync_a  <= '0;
            sync_b  <= '0;
            db_lvl  <= '0;
            rst_req <= 1'b0;
            for (int unsigned i = 0; i < 2; i++) begin
                held[i]   <= '0;
                pend[i]   <= '0;
                db_cnt[i] <= '0;
                pulse[i]  <= 1'b0;
                arrow[i]  <= '0;
            end
        end else begin
            state   <= state_nx;
            rst_req <= rst_hit;
            sync_a  <= shake_raw;
            sync_b  <= sync_a;
            for (int unsigned i = 0; i < 2; i++) begin
                if (sync_b[i] != db_lvl[i]) begin
                    if (db_cnt[i] == DB_LAST) begin
                        db_lvl[i] <= sync_b[i];
                        db_cnt[i] <= '0;
                    end else begin
                        db_cnt[i] <= db_cnt[i] + DB_W'(1);
                    end
                end else begin
                    db_cnt[i] <= '0;
                end

                if (make_code[i] != 3'd0)
                    held[i] <= make_code[i];
                else if (brk_code[i] != 3'd0 && brk_code[i] == held[i])
                    held[i] <= '0;

                // Shake wins a collision; the key event waits one cycle in the pending slot.
                pulse[i] <= 1'b0;
                if (shake_ev[i]) begin
                    pulse[i] <= 1'b1;
                    arrow[i] <= {5'b0, SHAKE_CODE};
                    if (key_ev[i] != 3'd0 && pend[i] == 3'd0)
                        pend[i] <= key_ev[i];
                end else if (pend[i] != 3'd0) begin
                    pulse[i] <= 1'b1;
                    arrow[i] <= {5'b0, pend[i]};
                    pend[i]  <= '0;
                end else if (key_ev[i] != 3'd0) begin
                    pulse[i] <= 1'b1;
                    arrow[i] <= {5'b0, key_ev[i]};
                end
            end
        end
    end

    assign bus.p1_key_pressed = pulse[0];
    assign bus.p1_arrow       = arrow[0];
    assign bus.p2_key_pressed = pulse[1];
    assign bus.p2_arrow       = arrow[1];
    assign bus.game_reset_req = rst_req;
endmodule

// File: tb/tb_ps2_arrow_decoder.sv
// Directed bench for ps2_arrow_decoder: a per-cycle reference model checks every
// output each cycle, plus literal expectations at the key points of each scenario.
module tb_ps2_arrow_decoder;
    localparam int DB = 8;

    logic clock = 1'b0;
    logic resetn;
    always #5 clock = ~clock;

    ps2_arrow_decoder_if bus();

    ps2_arrow_decoder #(
        .SHAKE_DEBOUNCE(16'(DB)),
        .DB_W(16),
        .RESET_CODE(8'h2D)
    ) dut (
        .clock(clock),
        .resetn(resetn),
        .bus(bus)
    );

    int n_checks = 0;
    int n_fail   = 0;
    int cnt_pulse[2] = '{0, 0};
    int cnt_shake[2] = '{0, 0};
    int cnt_rst      = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [2:0] lookup(input int p, input logic [7:0] b);
        logic [7:0] keys [2][4];
        keys = '{'{8'h1D, 8'h1C, 8'h1B, 8'h23}, '{8'h75, 8'h6B, 8'h72, 8'h74}};
        lookup = 3'd0;
        for (int k = 0; k < 4; k++)
            if (keys[p][k] == b) lookup = 3'(k + 1);
    endfunction

    // Reference model: prefix flags, held/pending per player, debounce by run length
    logic       m_ext, m_brk;
    logic [2:0] m_held[2], m_pend[2];
    int         m_run[2];
    logic       m_lvl[2], m_d1[2], m_d2[2];
    logic       exp_pulse[2];
    logic [7:0] exp_arrow[2];
    logic       exp_rst;

    always @(negedge clock) begin : model
        logic [2:0] mk[2];
        logic [2:0] bk[2];
        logic [2:0] kev;
        logic       syn, sev;
        logic [1:0] raw;
        raw = {bus.shake2_in, bus.shake1_in};
        if (!resetn) begin
            check("reset_p1_pulse", 32'(bus.p1_key_pressed), 32'd0);
            check("reset_p1_arrow", 32'(bus.p1_arrow), 32'd0);
            check("reset_p2_pulse", 32'(bus.p2_key_pressed), 32'd0);
            check("reset_p2_arrow", 32'(bus.p2_arrow), 32'd0);
            check("reset_req",      32'(bus.game_reset_req), 32'd0);
            m_ext = 1'b0; m_brk = 1'b0; exp_rst = 1'b0;
            for (int i = 0; i < 2; i++) begin
                m_held[i] = '0; m_pend[i] = '0; m_run[i] = 0; m_lvl[i] = 1'b0;
                m_d2[i] = 1'b0; m_d1[i] = raw[i];
                exp_pulse[i] = 1'b0; exp_arrow[i] = '0;
            end
        end else begin
            check("p1_pulse", 32'(bus.p1_key_pressed), 32'(exp_pulse[0]));
            check("p1_arrow", 32'(bus.p1_arrow), 32'(exp_arrow[0]));
            check("p2_pulse", 32'(bus.p2_key_pressed), 32'(exp_pulse[1]));
            check("p2_arrow", 32'(bus.p2_arrow), 32'(exp_arrow[1]));
            check("game_reset_req", 32'(bus.game_reset_req), 32'(exp_rst));
            if (bus.p1_key_pressed) cnt_pulse[0]++;
            if (bus.p2_key_pressed) cnt_pulse[1]++;
            if (bus.p1_key_pressed && bus.p1_arrow == 8'h05) cnt_shake[0]++;
            if (bus.p2_key_pressed && bus.p2_arrow == 8'h05) cnt_shake[1]++;
            if (bus.game_reset_req) cnt_rst++;

            mk = '{3'd0, 3'd0};
            bk = '{3'd0, 3'd0};
            exp_rst = 1'b0;
            if (bus.ps2_key_pressed) begin
                if (!m_ext && !m_brk) begin
                    if (bus.ps2_key_data == 8'hE0)      m_ext = 1'b1;
                    else if (bus.ps2_key_data == 8'hF0) m_brk = 1'b1;
                    else begin
                        mk[0] = lookup(0, bus.ps2_key_data);
                        mk[1] = lookup(1, bus.ps2_key_data);
                        exp_rst = (bus.ps2_key_data == 8'h2D);
                    end
                end else if (m_ext && !m_brk) begin
                    if (bus.ps2_key_data == 8'hF0) m_brk = 1'b1;
                    else begin
                        mk[1] = lookup(1, bus.ps2_key_data);
                        m_ext = 1'b0;
                    end
                end else begin
                    bk[1] = lookup(1, bus.ps2_key_data);
                    if (!m_ext) bk[0] = lookup(0, bus.ps2_key_data);
                    m_ext = 1'b0; m_brk = 1'b0;
                end
            end
            for (int i = 0; i < 2; i++) begin
                syn = m_d2[i]; m_d2[i] = m_d1[i]; m_d1[i] = raw[i];
                sev = 1'b0;
                if (syn != m_lvl[i]) begin
                    m_run[i]++;
                    if (m_run[i] == DB) begin
                        m_lvl[i] = syn; m_run[i] = 0; sev = syn;
                    end
                end else m_run[i] = 0;
                kev = (mk[i] != 0 && mk[i] != m_held[i]) ? mk[i] : 3'd0;
                if (mk[i] != 0) m_held[i] = mk[i];
                else if (bk[i] != 0 && bk[i] == m_held[i]) m_held[i] = 3'd0;
                exp_pulse[i] = 1'b0;
                if (sev) begin
                    exp_pulse[i] = 1'b1; exp_arrow[i] = 8'd5;
                    if (kev != 0 && m_pend[i] == 0) m_pend[i] = kev;
                end else if (m_pend[i] != 0) begin
                    exp_pulse[i] = 1'b1; exp_arrow[i] = {5'b0, m_pend[i]}; m_pend[i] = 3'd0;
                end else if (kev != 0) begin
                    exp_pulse[i] = 1'b1; exp_arrow[i] = {5'b0, kev};
                end
            end
        end
    end

    // Leaves the caller #1 after the edge where the byte's event (if any) is visible.
    task automatic send(input logic [7:0] b);
        @(posedge clock); #1;
        bus.ps2_key_data = b; bus.ps2_key_pressed = 1'b1;
        @(posedge clock); #1;
        bus.ps2_key_pressed = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    int c0, c1;

    initial begin
        resetn = 1'b0;
        bus.ps2_key_data = '0; bus.ps2_key_pressed = 1'b0;
        bus.shake1_in = 1'b0; bus.shake2_in = 1'b0;
        idle(3);
        check("lit_reset_p1_arrow", 32'(bus.p1_arrow), 32'd0);
        check("lit_reset_p2_pulse", 32'(bus.p2_key_pressed), 32'd0);
        resetn = 1'b1;
        idle(2);

        // T1: make, typematic repeats, break, make again
        c0 = cnt_pulse[0];
        send(8'h1D);
        check("t1_first_pulse", 32'(bus.p1_key_pressed), 32'd1);
        check("t1_first_arrow", 32'(bus.p1_arrow), 32'h01);
        for (int k = 0; k < 3; k++) begin
            send(8'h1D);
            check("t1_repeat_pulse", 32'(bus.p1_key_pressed), 32'd0);
        end
        send(8'hF0); send(8'h1D);
        check("t1_break_pulse", 32'(bus.p1_key_pressed), 32'd0);
        send(8'h1D);
        check("t1_second_pulse", 32'(bus.p1_key_pressed), 32'd1);
        check("t1_second_arrow", 32'(bus.p1_arrow), 32'h01);
        idle(2);
        check("t1_pulse_count", 32'(cnt_pulse[0] - c0), 32'd2);

        // T2: extended and plain P2 codes, extended break
        send(8'hE0); send(8'h75);
        check("t2_up_pulse", 32'(bus.p2_key_pressed), 32'd1);
        check("t2_up_arrow", 32'(bus.p2_arrow), 32'h01);
        send(8'h75);
        check("t2_repeat_pulse", 32'(bus.p2_key_pressed), 32'd0);
        send(8'hE0); send(8'hF0); send(8'h75);
        check("t2_break_pulse", 32'(bus.p2_key_pressed), 32'd0);
        send(8'h6B);
        check("t2_left_pulse", 32'(bus.p2_key_pressed), 32'd1);
        check("t2_left_arrow", 32'(bus.p2_arrow), 32'h02);
        idle(2);

        // T3: two stable shake periods and one short glitch on player 1
        c0 = cnt_shake[0]; c1 = cnt_pulse[0];
        bus.shake1_in = 1'b1; idle(DB + 3);
        bus.shake1_in = 1'b0; idle(DB + 3);
        check("t3_first_shake", 32'(cnt_shake[0] - c0), 32'd1);
        check("t3_arrow_shake", 32'(bus.p1_arrow), 32'h05);
        bus.shake1_in = 1'b1; idle(DB + 3);
        bus.shake1_in = 1'b0; idle(DB + 3);
        check("t3_second_shake", 32'(cnt_shake[0] - c0), 32'd2);
        bus.shake1_in = 1'b1; idle(DB - 2);
        bus.shake1_in = 1'b0; idle(DB + 4);
        check("t3_glitch_shake", 32'(cnt_shake[0] - c0), 32'd2);
        check("t3_pulse_total", 32'(cnt_pulse[0] - c1), 32'd2);

        // T4: shake2 debounce completes in the cycle the E0,74 make is strobed
        send(8'hE0);
        bus.shake2_in = 1'b1;
        repeat (DB + 1) @(posedge clock);
        #1;
        bus.ps2_key_data = 8'h74; bus.ps2_key_pressed = 1'b1;
        @(posedge clock); #1;
        bus.ps2_key_pressed = 1'b0;
        check("t4_shake_pulse", 32'(bus.p2_key_pressed), 32'd1);
        check("t4_shake_arrow", 32'(bus.p2_arrow), 32'h05);
        @(posedge clock); #1;
        check("t4_pending_pulse", 32'(bus.p2_key_pressed), 32'd1);
        check("t4_pending_arrow", 32'(bus.p2_arrow), 32'h04);
        @(posedge clock); #1;
        check("t4_after_pulse", 32'(bus.p2_key_pressed), 32'd0);
        bus.shake2_in = 1'b0; idle(DB + 5);

        // T5: reset code only counts from IDLE
        c0 = cnt_rst;
        send(8'h2D);
        check("t5_req_pulse", 32'(bus.game_reset_req), 32'd1);
        send(8'hF0); send(8'h2D);
        check("t5_break_req", 32'(bus.game_reset_req), 32'd0);
        send(8'hE0); send(8'h2D);
        check("t5_ext_req", 32'(bus.game_reset_req), 32'd0);
        idle(2);
        check("t5_req_count", 32'(cnt_rst - c0), 32'd1);

        // T6: reset between E0 and 72
        send(8'hE0);
        resetn = 1'b0; #1;
        check("t6_p1_arrow", 32'(bus.p1_arrow), 32'd0);
        check("t6_p2_arrow", 32'(bus.p2_arrow), 32'd0);
        idle(2);
        resetn = 1'b1;
        idle(1);
        send(8'h72);
        check("t6_down_pulse", 32'(bus.p2_key_pressed), 32'd1);
        check("t6_down_arrow", 32'(bus.p2_arrow), 32'h03);
        idle(3);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
